wb_arbiter: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter.
- Shares the system bus between the CPU (master 0) and a secondary master (master 1, e.g. a debug/loader or DMA engine).
- Round-robin on contention; the grant is held for the whole cycle (cyc asserted), so the CPU's fetch and memory phases are never split.
- Sits between the masters and the bus interconnect/address decoder.

---
 rtl/wb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
//==============================================================================
// Module      : wb_arbiter
// Description : Two-master / one-slave Wishbone classic arbiter, round-robin
//               on contention, grant held for the whole cyc. Optional stalled
//               transfer timeout enabled by defining WB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_last_owner;
    logic [1:0] r_grant;
    logic       w_timeout;

    // r_grant is the one-hot image of r_state; the datapath mux keys off it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_owner <= 1'b1;
            r_grant      <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || r_last_owner)) begin
                        r_state      <= GRANT0;
                        r_last_owner <= 1'b0;
                        r_grant      <= 2'b01;
                    end else if (m1_cyc_i) begin
                        r_state      <= GRANT1;
                        r_last_owner <= 1'b1;
                        r_grant      <= 2'b10;
                    end
                end
                GRANT0: begin
                    if (!m0_cyc_i) begin
                        if (m1_cyc_i) begin
                            r_state      <= GRANT1;
                            r_last_owner <= 1'b1;
                            r_grant      <= 2'b10;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                        end
                    end
                end
                GRANT1: begin
                    if (!m1_cyc_i) begin
                        if (m0_cyc_i) begin
                            r_state      <= GRANT0;
                            r_last_owner <= 1'b0;
                            r_grant      <= 2'b01;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_count;
    logic        w_owner_cyc;
    logic        w_owner_stb;
    logic        w_resp;

    assign w_owner_cyc = (r_grant[0] & m0_cyc_i) | (r_grant[1] & m1_cyc_i);
    assign w_owner_stb = (r_grant[0] & m0_stb_i) | (r_grant[1] & m1_stb_i);
    assign w_resp      = s_ack_i | s_err_i | s_rty_i;
    // Fires on the stalled clock that brings the count to TIMEOUT_CYCLES.
    assign w_timeout   = w_owner_stb && !w_resp && (r_count == c_timeout_last);

    // Owner dropping cyc is the only way the grant changes, so it clears too.
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_owner_cyc || w_resp || w_timeout) begin
            r_count <= 16'd0;
        end else if (w_owner_stb) begin
            r_count <= r_count + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = 32'd0;
        s_sel_o  = 4'd0;
        s_dat_o  = 32'd0;
        m0_dat_o = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        if (r_grant[0]) begin
            s_cyc_o  = m0_cyc_i & ~w_timeout;
            s_stb_o  = m0_stb_i & ~w_timeout;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_sel_o  = m0_sel_i;
            s_dat_o  = m0_dat_i;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | w_timeout;
            m0_rty_o = s_rty_i;
        end else if (r_grant[1]) begin
            s_cyc_o  = m1_cyc_i & ~w_timeout;
            s_stb_o  = m1_stb_i & ~w_timeout;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_sel_o  = m1_sel_i;
            s_dat_o  = m1_dat_i;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | w_timeout;
            m1_rty_o = s_rty_i;
        end
    end

    assign grant_o = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//==============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter: vector table, random
//               traffic against an ownership model, and directed corner cases.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_arbiter;

    localparam int TO = 4;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [31:0] m0_adr_i = 0, m0_dat_i = 0;
    logic [3:0]  m0_sel_i = 0;
    logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [31:0] m1_adr_i = 0, m1_dat_i = 0;
    logic [3:0]  m1_sel_i = 0;
    logic [31:0] s_dat_i = 0;
    logic        s_ack_i = 0, s_err_i = 0, s_rty_i = 0;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  grant_o;

    wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = nobody), previous owner, stall count.
    int own = -1;
    int last = 1;
    int cnt = 0;
    bit model_on = 1'b0;

    function automatic logic cyc_of(int i);
        return (i == 0) ? m0_cyc_i : m1_cyc_i;
    endfunction

    function automatic logic stb_of(int i);
        return (i == 0) ? m0_stb_i : m1_stb_i;
    endfunction

    function automatic logic timeout_now();
        return TO_EN && own >= 0 && stb_of(own) && !(s_ack_i | s_err_i | s_rty_i)
               && cnt == TO - 1;
    endfunction

    always @(posedge clk_i) begin : model
        int   nown;
        logic t;
        t = timeout_now();
        if (rst_i) begin
            own = -1; last = 1; cnt = 0;
        end else begin
            nown = own;
            if (own < 0) begin
                if (m0_cyc_i && m1_cyc_i) nown = 1 - last;
                else if (m0_cyc_i)        nown = 0;
                else if (m1_cyc_i)        nown = 1;
            end else if (!cyc_of(own)) begin
                nown = cyc_of(1 - own) ? 1 - own : -1;
            end
            if (nown != own || s_ack_i || s_err_i || s_rty_i || t) cnt = 0;
            else if (own >= 0 && stb_of(own)) cnt = cnt + 1;
            if (nown >= 0 && nown != own) last = nown;
            own = nown;
        end
    end

    always @(negedge clk_i) begin : scoreboard
        logic        t, e_cyc, e_stb, e_we;
        logic [31:0] e_adr, e_sdat;
        logic [3:0]  e_sel;
        logic [1:0]  e_ack, e_err, e_rty;
        logic [31:0] e_d0, e_d1;
        if (model_on) begin
            t = timeout_now();
            e_cyc = 0; e_stb = 0; e_we = 0; e_adr = 0; e_sdat = 0; e_sel = 0;
            e_ack = 0; e_err = 0; e_rty = 0; e_d0 = 0; e_d1 = 0;
            if (own == 0) begin
                e_cyc = m0_cyc_i & ~t; e_stb = m0_stb_i & ~t; e_we = m0_we_i;
                e_adr = m0_adr_i; e_sel = m0_sel_i; e_sdat = m0_dat_i;
                e_ack[0] = s_ack_i; e_err[0] = s_err_i | t; e_rty[0] = s_rty_i; e_d0 = s_dat_i;
            end else if (own == 1) begin
                e_cyc = m1_cyc_i & ~t; e_stb = m1_stb_i & ~t; e_we = m1_we_i;
                e_adr = m1_adr_i; e_sel = m1_sel_i; e_sdat = m1_dat_i;
                e_ack[1] = s_ack_i; e_err[1] = s_err_i | t; e_rty[1] = s_rty_i; e_d1 = s_dat_i;
            end
            check("mdl_grant", grant_o, (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00);
            check("mdl_s_cyc", s_cyc_o, e_cyc);
            check("mdl_s_stb", s_stb_o, e_stb);
            check("mdl_s_we",  s_we_o,  e_we);
            check("mdl_s_adr", s_adr_o, e_adr);
            check("mdl_s_sel", s_sel_o, e_sel);
            check("mdl_s_dat", s_dat_o, e_sdat);
            check("mdl_m0_ack", m0_ack_o, e_ack[0]);
            check("mdl_m0_err", m0_err_o, e_err[0]);
            check("mdl_m0_rty", m0_rty_o, e_rty[0]);
            check("mdl_m0_dat", m0_dat_o, e_d0);
            check("mdl_m1_ack", m1_ack_o, e_ack[1]);
            check("mdl_m1_err", m1_err_o, e_err[1]);
            check("mdl_m1_rty", m1_rty_o, e_rty[1]);
            check("mdl_m1_dat", m1_dat_o, e_d1);
        end
    end

    task automatic drive(input logic r, input logic c0, input logic c1,
                         input logic ack, input logic err);
        @(posedge clk_i);
        #1;
        rst_i = r; m0_cyc_i = c0; m0_stb_i = c0; m1_cyc_i = c1; m1_stb_i = c1;
        s_ack_i = ack; s_err_i = err; s_rty_i = 1'b0;
    endtask

    typedef struct {
        logic        rst, c0, c1, ack, err;
        logic [1:0]  grant;
        logic        scyc;
        logic [31:0] adr;
        logic        a0, a1, e0, e1;
    } vec_t;

    vec_t tbl[15];
    int   err_pulses;
    logic exp_err;

    initial begin
        // rst c0 c1 ack err | grant scyc adr a0 a1 e0 e1
        tbl[0]  = '{0, 1, 0, 0, 0, 2'b00, 0, 32'h000, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1, 0, 2'b01, 1, 32'h100, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 2'b01, 0, 32'h100, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 2'b00, 0, 32'h000, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 0, 2'b00, 0, 32'h000, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 1, 0, 2'b01, 1, 32'h100, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 0, 0, 2'b01, 0, 32'h100, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 1, 0, 2'b10, 1, 32'h200, 0, 1, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 2'b10, 0, 32'h200, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 0, 1, 2'b01, 1, 32'h100, 0, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 2'b01, 0, 32'h100, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 0, 2'b00, 0, 32'h000, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 1, 0, 0, 2'b10, 1, 32'h200, 0, 0, 0, 0};
        tbl[13] = '{1, 1, 1, 0, 0, 2'b10, 1, 32'h200, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 2'b00, 0, 32'h000, 0, 0, 0, 0};

        m0_adr_i = 32'h100; m1_adr_i = 32'h200; m0_sel_i = 4'hF; m1_sel_i = 4'hF;
        m0_dat_i = 32'h1111_0000; m1_dat_i = 32'h2222_0000; s_dat_i = 32'hDEAD_BEEF;

        @(posedge clk_i);
        #1 model_on = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_grant", grant_o, 2'b00);
        check("rst_s_cyc", s_cyc_o, 1'b0);
        check("rst_m0_ack", m0_ack_o, 1'b0);
        check("rst_m1_ack", m1_ack_o, 1'b0);
        check("rst_m0_dat", m0_dat_o, 32'd0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rst, tbl[i].c0, tbl[i].c1, tbl[i].ack, tbl[i].err);
            @(negedge clk_i);
            check($sformatf("vec%0d_grant", i), grant_o, tbl[i].grant);
            check($sformatf("vec%0d_s_cyc", i), s_cyc_o, tbl[i].scyc);
            check($sformatf("vec%0d_s_adr", i), s_adr_o, tbl[i].adr);
            check($sformatf("vec%0d_m0_ack", i), m0_ack_o, tbl[i].a0);
            check($sformatf("vec%0d_m1_ack", i), m1_ack_o, tbl[i].a1);
            check($sformatf("vec%0d_m0_err", i), m0_err_o, tbl[i].e0);
            check($sformatf("vec%0d_m1_err", i), m1_err_o, tbl[i].e1);
            if (tbl[i].a0)
                check($sformatf("vec%0d_m0_dat", i), m0_dat_o, 32'hDEAD_BEEF);
        end

        // Random traffic, checked by the scoreboard every cycle.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_i);
            #1;
            rst_i = ($urandom_range(49) == 0);
            if ($urandom_range(3) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(3) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = m0_cyc_i & ($urandom_range(3) != 0);
            m1_stb_i = m1_cyc_i & ($urandom_range(3) != 0);
            m0_we_i = 1'($urandom_range(1)); m1_we_i = 1'($urandom_range(1));
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_sel_i = 4'($urandom_range(15)); m1_sel_i = 4'($urandom_range(15));
            m0_dat_i = $urandom; m1_dat_i = $urandom; s_dat_i = $urandom;
            s_ack_i = ($urandom_range(3) == 0);
            s_err_i = ($urandom_range(9) == 0);
            s_rty_i = ($urandom_range(9) == 0);
        end

        @(posedge clk_i);
        #1;
        m0_adr_i = 32'h100; m1_adr_i = 32'h200; m0_we_i = 0; m1_we_i = 0;
        m0_sel_i = 4'hF; m1_sel_i = 4'hF; s_dat_i = 32'hDEAD_BEEF;

        // m1 holds the bus for 10 clocks while m0 waits.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 1, 0, 0);
            @(negedge clk_i);
            check($sformatf("hold%0d_grant", k), grant_o, 2'b10);
            check($sformatf("hold%0d_s_adr", k), s_adr_o, 32'h200);
        end
        drive(0, 1, 0, 0, 0);
        @(negedge clk_i);
        check("hold_release_grant", grant_o, 2'b10);
        drive(0, 1, 0, 0, 0);
        @(negedge clk_i);
        check("hold_handover_grant", grant_o, 2'b01);

        // m0 lets go, m1 writes and receives a slave error.
        drive(0, 0, 1, 0, 0);
        @(negedge clk_i);
        #2;
        m1_we_i = 1'b1; m1_sel_i = 4'b0100; m1_dat_i = 32'h00AB_0000;
        drive(0, 0, 1, 0, 1);
        @(negedge clk_i);
        check("wr_grant", grant_o, 2'b10);
        check("wr_s_we", s_we_o, 1'b1);
        check("wr_s_sel", s_sel_o, 4'b0100);
        check("wr_s_dat", s_dat_o, 32'h00AB_0000);
        check("wr_m1_err", m1_err_o, 1'b1);
        check("wr_m0_err", m0_err_o, 1'b0);
        check("wr_m0_ack", m0_ack_o, 1'b0);
        drive(0, 0, 1, 0, 0);
        @(negedge clk_i);
        check("wr_m1_err_end", m1_err_o, 1'b0);

        // Reset while m0 is mid-transfer.
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        @(negedge clk_i);
        check("rstmid_grant_pre", grant_o, 2'b01);
        drive(1, 1, 0, 1, 0);
        @(negedge clk_i);
        check("rstmid_s_cyc_pre", s_cyc_o, 1'b1);
        drive(0, 1, 0, 1, 0);
        @(negedge clk_i);
        check("rstmid_grant", grant_o, 2'b00);
        check("rstmid_s_cyc", s_cyc_o, 1'b0);
        check("rstmid_m0_ack", m0_ack_o, 1'b0);
        check("rstmid_m0_err", m0_err_o, 1'b0);
        check("rstmid_m1_ack", m1_ack_o, 1'b0);

        // m0 now owns the bus and the slave never answers.
        err_pulses = 0;
        for (int k = 1; k <= TO + 2; k++) begin
            drive(0, 1, 0, 0, 0);
            @(negedge clk_i);
            exp_err = TO_EN && (k == TO);
            if (m0_err_o) err_pulses++;
            check($sformatf("stall%0d_grant", k), grant_o, 2'b01);
            check($sformatf("stall%0d_m0_err", k), m0_err_o, exp_err);
            check($sformatf("stall%0d_s_cyc", k), s_cyc_o, !exp_err);
        end
        check("stall_err_pulses", err_pulses, TO_EN ? 1 : 0);

        drive(1, 0, 0, 0, 0);
        @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
